// File: rtl/strat_decide_mc_if.sv
// Bundle of config, BBO, fill and decision signals between the order book side and the decider.
// master drives stimulus/config; slave is the decider itself.
interface strat_decide_mc_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned SYMW = 2,
  parameter int unsigned POSW = 16
);
  logic                   cfg_we;
  logic [SYMW-1:0]        cfg_sym;
  logic [1:0]             cfg_addr;
  logic [W-1:0]           cfg_wdata;
  logic [POSW-2:0]        pos_limit;
  logic                   in_valid;
  logic                   in_ready;
  logic [SYMW-1:0]        in_sym;
  logic [W-1:0]           bid_px0;
  logic [W-1:0]           ask_px0;
  logic                   fill_valid;
  logic [SYMW-1:0]        fill_sym;
  logic                   fill_side;
  logic [POSW-2:0]        fill_qty;
  logic                   out_valid;
  logic                   out_ready;
  logic [SYMW-1:0]        out_sym;
  logic                   buy;
  logic                   sell;
  logic signed [POSW-1:0] pos_out;
  logic [15:0]            conflict_cnt;
  logic [15:0]            suppress_cnt;

  modport master (
    output cfg_we, cfg_sym, cfg_addr, cfg_wdata, pos_limit,
    output in_valid, in_sym, bid_px0, ask_px0,
    output fill_valid, fill_sym, fill_side, fill_qty, out_ready,
    input  in_ready, out_valid, out_sym, buy, sell, pos_out, conflict_cnt, suppress_cnt
  );

  modport slave (
    input  cfg_we, cfg_sym, cfg_addr, cfg_wdata, pos_limit,
    input  in_valid, in_sym, bid_px0, ask_px0,
    input  fill_valid, fill_sym, fill_side, fill_qty, out_ready,
    output in_ready, out_valid, out_sym, buy, sell, pos_out, conflict_cnt, suppress_cnt
  );
endinterface

// File: rtl/strat_decide_mc.sv
// Multi-symbol BBO threshold decider: 2-stage pipeline with per-symbol config,
// cooldown timers and signed position limits gating buy/sell decisions.
module strat_decide_mc #(
  parameter int unsigned W    = 32,
  parameter int unsigned NSYM = 4,
  parameter int unsigned SYMW = 2,
  parameter int unsigned CDW  = 16,
  parameter int unsigned POSW = 16
) (
  input logic             clk,
  input logic             rst,
  strat_decide_mc_if.slave bus_io
);

  localparam logic signed [POSW:0] PosMax = {2'b00, {(POSW-1){1'b1}}};
  localparam logic signed [POSW:0] PosMin = {2'b11, {(POSW-1){1'b0}}};

  logic [NSYM-1:0][W-1:0]    fair_q, fair_d, tb_q, tb_d, ts_q, ts_d;
  logic [NSYM-1:0][CDW-1:0]  cd_q, cd_d, tmr_q, tmr_d;
  logic [NSYM-1:0][POSW-1:0] pos_q, pos_d;

  logic            s1_valid_q, s1_valid_d;
  logic [SYMW-1:0] s1_sym_q, s1_sym_d;
  logic [W-1:0]    s1_bid_q, s1_bid_d, s1_ask_q, s1_ask_d;
  logic [W-1:0]    s1_fair_q, s1_fair_d, s1_tb_q, s1_tb_d, s1_ts_q, s1_ts_d;

  logic            out_valid_q, out_valid_d;
  logic [SYMW-1:0] out_sym_q, out_sym_d;
  logic            buy_q, buy_d, sell_q, sell_d;
  logic [POSW-1:0] pos_out_q, pos_out_d;
  logic [15:0]     conflict_q, conflict_d, suppress_q, suppress_d;

  logic adv, in_ready, accept;
  logic buy_c, sell_c, conflict, buy_blk, sell_blk, buy_g, sell_g, suppressed, cd_busy;
  logic [POSW-1:0]        cur_pos;
  logic signed [POSW:0]   pos_ext, lim_ext, nlim_ext;
  logic signed [POSW:0]   fpos_ext, fqty_ext, fsum;

  assign adv      = s1_valid_q & (~out_valid_q | bus_io.out_ready);
  assign in_ready = ~s1_valid_q | adv;
  assign accept   = bus_io.in_valid & in_ready;

  // Compare at W+1 bits so ask+tb and fair+ts can never wrap.
  assign buy_c    = ({1'b0, s1_ask_q} + {1'b0, s1_tb_q}) < {1'b0, s1_fair_q};
  assign sell_c   = {1'b0, s1_bid_q} > ({1'b0, s1_fair_q} + {1'b0, s1_ts_q});
  assign conflict = buy_c & sell_c;

  assign cur_pos  = pos_q[s1_sym_q];
  assign cd_busy  = tmr_q[s1_sym_q] != '0;
  assign pos_ext  = {cur_pos[POSW-1], cur_pos};
  assign lim_ext  = {2'b00, bus_io.pos_limit};
  assign nlim_ext = -lim_ext;
  assign buy_blk  = cd_busy | (pos_ext >= lim_ext);
  assign sell_blk = cd_busy | (pos_ext <= nlim_ext);

  assign buy_g      = buy_c & ~sell_c & ~buy_blk;
  assign sell_g     = sell_c & ~buy_c & ~sell_blk;
  assign suppressed = (buy_c & ~sell_c & buy_blk) | (sell_c & ~buy_c & sell_blk);

  assign fpos_ext = {pos_q[bus_io.fill_sym][POSW-1], pos_q[bus_io.fill_sym]};
  assign fqty_ext = {2'b00, bus_io.fill_qty};
  assign fsum     = bus_io.fill_side ? (fpos_ext + fqty_ext) : (fpos_ext - fqty_ext);

  always_comb begin
    fair_d = fair_q;
    tb_d   = tb_q;
    ts_d   = ts_q;
    cd_d   = cd_q;
    if (bus_io.cfg_we) begin
      unique case (bus_io.cfg_addr)
        2'd0: fair_d[bus_io.cfg_sym] = bus_io.cfg_wdata;
        2'd1: tb_d[bus_io.cfg_sym]   = bus_io.cfg_wdata;
        2'd2: ts_d[bus_io.cfg_sym]   = bus_io.cfg_wdata;
        2'd3: cd_d[bus_io.cfg_sym]   = bus_io.cfg_wdata[CDW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (adv && (buy_g || sell_g) && (s1_sym_q == SYMW'(i))) begin
        tmr_d[i] = cd_q[i];
      end else if (tmr_q[i] != '0) begin
        tmr_d[i] = tmr_q[i] - CDW'(1);
      end else begin
        tmr_d[i] = tmr_q[i];
      end
    end
  end

  // Gating above reads pos_q, so a same-cycle fill only affects later decisions.
  always_comb begin
    pos_d = pos_q;
    if (bus_io.fill_valid) begin
      if (fsum > PosMax) begin
        pos_d[bus_io.fill_sym] = PosMax[POSW-1:0];
      end else if (fsum < PosMin) begin
        pos_d[bus_io.fill_sym] = PosMin[POSW-1:0];
      end else begin
        pos_d[bus_io.fill_sym] = fsum[POSW-1:0];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sym_d   = s1_sym_q;
    s1_bid_d   = s1_bid_q;
    s1_ask_d   = s1_ask_q;
    s1_fair_d  = s1_fair_q;
    s1_tb_d    = s1_tb_q;
    s1_ts_d    = s1_ts_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sym_d   = bus_io.in_sym;
      s1_bid_d   = bus_io.bid_px0;
      s1_ask_d   = bus_io.ask_px0;
      s1_fair_d  = fair_q[bus_io.in_sym];
      s1_tb_d    = tb_q[bus_io.in_sym];
      s1_ts_d    = ts_q[bus_io.in_sym];
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    buy_d       = buy_q;
    sell_d      = sell_q;
    pos_out_d   = pos_out_q;
    conflict_d  = conflict_q;
    suppress_d  = suppress_q;
    if (adv) begin
      out_valid_d = 1'b1;
      out_sym_d   = s1_sym_q;
      buy_d       = buy_g;
      sell_d      = sell_g;
      pos_out_d   = cur_pos;
      if (conflict && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
      if (suppressed && (suppress_q != 16'hFFFF)) suppress_d = suppress_q + 16'd1;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fair_q      <= '0;
      tb_q        <= '0;
      ts_q        <= '0;
      cd_q        <= '0;
      tmr_q       <= '0;
      pos_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sym_q    <= '0;
      s1_bid_q    <= '0;
      s1_ask_q    <= '0;
      s1_fair_q   <= '0;
      s1_tb_q     <= '0;
      s1_ts_q     <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      buy_q       <= 1'b0;
      sell_q      <= 1'b0;
      pos_out_q   <= '0;
      conflict_q  <= '0;
      suppress_q  <= '0;
    end else begin
      fair_q      <= fair_d;
      tb_q        <= tb_d;
      ts_q        <= ts_d;
      cd_q        <= cd_d;
      tmr_q       <= tmr_d;
      pos_q       <= pos_d;
      s1_valid_q  <= s1_valid_d;
      s1_sym_q    <= s1_sym_d;
      s1_bid_q    <= s1_bid_d;
      s1_ask_q    <= s1_ask_d;
      s1_fair_q   <= s1_fair_d;
      s1_tb_q     <= s1_tb_d;
      s1_ts_q     <= s1_ts_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      buy_q       <= buy_d;
      sell_q      <= sell_d;
      pos_out_q   <= pos_out_d;
      conflict_q  <= conflict_d;
      suppress_q  <= suppress_d;
    end
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.out_valid    = out_valid_q;
  assign bus_io.out_sym      = out_sym_q;
  assign bus_io.buy          = buy_q;
  assign bus_io.sell         = sell_q;
  assign bus_io.pos_out      = pos_out_q;
  assign bus_io.conflict_cnt = conflict_q;
  assign bus_io.suppress_cnt = suppress_q;

endmodule

// File: tb/tb_strat_decide_mc.sv
// Randomized scoreboard bench for strat_decide_mc with a cycle-level reference model
// built from timestamps and plain integer arithmetic.
module tb_strat_decide_mc;
  localparam int unsigned W = 32, NSYM = 4, SYMW = 2, CDW = 16, POSW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  strat_decide_mc_if #(.W(W), .SYMW(SYMW), .POSW(POSW)) bus_if ();

  strat_decide_mc #(.W(W), .NSYM(NSYM), .SYMW(SYMW), .CDW(CDW), .POSW(POSW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus_if)
  );

  typedef struct {int sym; bit buy; bit sell; int pos;} dec_t;
  dec_t exp_q[$];
  dec_t seen[$];
  int   n_cmp = 0, n_err = 0;
  bit   checking = 0;
  bit   acc_last = 0;

  // Reference model state
  longint m_fair[NSYM], m_tb[NSYM], m_ts[NSYM];
  int     m_cd[NSYM], m_pos[NSYM], m_fire_cd[NSYM];
  bit     m_fired[NSYM];
  longint m_fire_t[NSYM];
  bit     m_s1_v, m_out_full;
  int     m_s1_sym;
  longint m_s1_bid, m_s1_ask, m_s1_fair, m_s1_tb, m_s1_ts;
  int     m_conf, m_supp;
  longint now = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit adv, acc, bc, sc, blk, bok, sok;
    int s, p, lim;
    if (rst) begin
      for (int i = 0; i < NSYM; i++) begin
        m_fair[i] = 0; m_tb[i] = 0; m_ts[i] = 0; m_cd[i] = 0; m_pos[i] = 0;
        m_fired[i] = 0; m_fire_t[i] = 0; m_fire_cd[i] = 0;
      end
      m_s1_v = 0; m_out_full = 0; m_conf = 0; m_supp = 0;
      exp_q.delete();
    end else begin
      adv = m_s1_v && (!m_out_full || bus_if.out_ready);
      acc = bus_if.in_valid && (!m_s1_v || adv);
      if (adv) begin
        s   = m_s1_sym;
        lim = int'(bus_if.pos_limit);
        bc  = (m_s1_ask + m_s1_tb) < m_s1_fair;
        sc  = m_s1_bid > (m_s1_fair + m_s1_ts);
        blk = m_fired[s] && ((now - m_fire_t[s]) <= longint'(m_fire_cd[s]));
        bok = 0; sok = 0;
        if (bc && sc) begin
          if (m_conf < 65535) m_conf++;
        end else begin
          bok = bc && !blk && (m_pos[s] < lim);
          sok = sc && !blk && (m_pos[s] > -lim);
          if ((bc && !bok) || (sc && !sok)) begin
            if (m_supp < 65535) m_supp++;
          end
        end
        if (bok || sok) begin
          m_fired[s] = 1; m_fire_t[s] = now; m_fire_cd[s] = m_cd[s];
        end
        exp_q.push_back('{sym: s, buy: bok, sell: sok, pos: m_pos[s]});
        m_out_full = 1;
      end else if (bus_if.out_ready) begin
        m_out_full = 0;
      end
      if (acc) begin
        m_s1_v    = 1;
        m_s1_sym  = int'(bus_if.in_sym);
        m_s1_bid  = longint'(bus_if.bid_px0);
        m_s1_ask  = longint'(bus_if.ask_px0);
        m_s1_fair = m_fair[m_s1_sym];
        m_s1_tb   = m_tb[m_s1_sym];
        m_s1_ts   = m_ts[m_s1_sym];
      end else if (adv) begin
        m_s1_v = 0;
      end
      if (bus_if.cfg_we) begin
        case (bus_if.cfg_addr)
          2'd0: m_fair[bus_if.cfg_sym] = longint'(bus_if.cfg_wdata);
          2'd1: m_tb[bus_if.cfg_sym]   = longint'(bus_if.cfg_wdata);
          2'd2: m_ts[bus_if.cfg_sym]   = longint'(bus_if.cfg_wdata);
          default: m_cd[bus_if.cfg_sym] = int'(bus_if.cfg_wdata % 65536);
        endcase
      end
      if (bus_if.fill_valid) begin
        p = m_pos[bus_if.fill_sym] + (bus_if.fill_side ? int'(bus_if.fill_qty)
                                                       : -int'(bus_if.fill_qty));
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        m_pos[bus_if.fill_sym] = p;
      end
    end
    now++;
  end

  // Monitor: inputs and DUT state are settled at the falling edge.
  always @(negedge clk) begin : monitor
    dec_t e;
    if (checking && !rst) begin
      chk("out_valid", bus_if.out_valid, m_out_full);
      chk("in_ready", bus_if.in_ready, !m_s1_v || !m_out_full || bus_if.out_ready);
      chk("conflict_cnt", bus_if.conflict_cnt, m_conf);
      chk("suppress_cnt", bus_if.suppress_cnt, m_supp);
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_decision", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dec_sym", bus_if.out_sym, e.sym);
          chk("dec_buy", bus_if.buy, e.buy);
          chk("dec_sell", bus_if.sell, e.sell);
          chk("dec_pos", bus_if.pos_out, e.pos);
          seen.push_back('{sym: int'(bus_if.out_sym), buy: bus_if.buy, sell: bus_if.sell,
                           pos: int'(bus_if.pos_out)});
        end
      end
    end
  end

  task automatic tick();
    #1;
    acc_last = bus_if.in_valid & bus_if.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int sym, input int addr, input logic [31:0] data);
    bus_if.cfg_we = 1; bus_if.cfg_sym = sym[1:0]; bus_if.cfg_addr = addr[1:0];
    bus_if.cfg_wdata = data;
    tick();
    bus_if.cfg_we = 0;
  endtask

  task automatic bbo(input int sym, input logic [31:0] bid, input logic [31:0] ask);
    bus_if.in_valid = 1; bus_if.in_sym = sym[1:0]; bus_if.bid_px0 = bid; bus_if.ask_px0 = ask;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (acc_last) break;
    end
    bus_if.in_valid = 0;
    chk("bbo_accept", acc_last, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !m_s1_v && !bus_if.out_valid) break;
      tick();
    end
    chk("drain", (exp_q.size() == 0 && !m_s1_v && !bus_if.out_valid), 1);
  endtask

  initial begin : main
    int n_acc, n_seen;
    bus_if.cfg_we = 0; bus_if.cfg_sym = 0; bus_if.cfg_addr = 0; bus_if.cfg_wdata = 0;
    bus_if.pos_limit = 0; bus_if.in_valid = 0; bus_if.in_sym = 0;
    bus_if.bid_px0 = 0; bus_if.ask_px0 = 0; bus_if.fill_valid = 0; bus_if.fill_sym = 0;
    bus_if.fill_side = 0; bus_if.fill_qty = 0; bus_if.out_ready = 1;
    rst = 1;
    tick(); tick(); tick();
    rst = 0;
    checking = 1;
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_in_ready", bus_if.in_ready, 1);
    chk("rst_buy", bus_if.buy, 0);
    chk("rst_pos_out", bus_if.pos_out, 0);
    chk("rst_conflict", bus_if.conflict_cnt, 0);
    bus_if.pos_limit = 100;

    // Basic buy with 2-cycle latency
    cfg_wr(1, 0, 1000); cfg_wr(1, 1, 5); cfg_wr(1, 2, 1000);
    bbo(1, 900, 990);
    chk("lat_early", bus_if.out_valid, 0);
    tick();
    chk("lat_valid", bus_if.out_valid, 1);
    chk("t1_sym", bus_if.out_sym, 1);
    chk("t1_buy", bus_if.buy, 1);
    chk("t1_sell", bus_if.sell, 0);
    drain();

    // Overflow: 32-bit ask+tb would wrap below fair
    cfg_wr(3, 0, 32'hFFFF_FFFF); cfg_wr(3, 1, 32'h20); cfg_wr(3, 2, 0);
    bbo(3, 0, 32'hFFFF_FFF0);
    drain();
    chk("ovf_buy", seen[$].buy, 0);

    // Cooldown on sym0
    cfg_wr(0, 0, 1000); cfg_wr(0, 1, 0); cfg_wr(0, 2, 1000); cfg_wr(0, 3, 3);
    bbo(0, 0, 500);
    bbo(0, 0, 500);
    drain();
    chk("cd_first_buy", seen[$-1].buy, 1);
    chk("cd_second_buy", seen[$].buy, 0);
    chk("cd_suppress", bus_if.suppress_cnt, 1);
    tick(); tick(); tick(); tick();
    bbo(0, 0, 500);
    drain();
    chk("cd_expired_buy", seen[$].buy, 1);

    // Position limit on sym2
    bus_if.pos_limit = 10;
    cfg_wr(2, 0, 1000); cfg_wr(2, 1, 0); cfg_wr(2, 2, 0);
    bus_if.fill_valid = 1; bus_if.fill_sym = 2; bus_if.fill_side = 1; bus_if.fill_qty = 10;
    tick();
    bus_if.fill_valid = 0;
    bbo(2, 0, 500);
    drain();
    chk("lim_buy", seen[$].buy, 0);
    chk("lim_pos", seen[$].pos, 10);
    chk("lim_suppress", bus_if.suppress_cnt, 2);
    bbo(2, 2000, 1500);
    drain();
    chk("lim_sell", seen[$].sell, 1);

    // Backpressure: three BBOs into a stalled output
    n_seen = seen.size();
    n_acc = 0;
    bus_if.out_ready = 0;
    bus_if.in_sym = 1; bus_if.bid_px0 = 900;
    for (int k = 0; k < 5; k++) begin
      bus_if.in_valid = 1; bus_if.ask_px0 = 32'(980 - n_acc);
      tick();
      if (acc_last) n_acc++;
      if (k >= 2) begin
        chk("hold_valid", bus_if.out_valid, 1);
        chk("hold_sym", bus_if.out_sym, 1);
        chk("hold_buy", bus_if.buy, 1);
      end
    end
    chk("hold_accepted", n_acc, 2);
    chk("hold_in_ready", bus_if.in_ready, 0);
    bus_if.out_ready = 1;
    for (int k = 0; k < 20 && n_acc < 3; k++) begin
      tick();
      if (acc_last) n_acc++;
    end
    bus_if.in_valid = 0;
    drain();
    chk("hold_count", seen.size() - n_seen, 3);

    // Crossed parameters
    cfg_wr(3, 0, 100); cfg_wr(3, 1, 0); cfg_wr(3, 2, 0);
    bbo(3, 150, 50);
    drain();
    chk("cross_buy", seen[$].buy, 0);
    chk("cross_sell", seen[$].sell, 0);
    chk("cross_conflict", bus_if.conflict_cnt, 1);

    // Reset with both stages occupied
    bus_if.out_ready = 0;
    bbo(3, 150, 50);
    bbo(3, 150, 50);
    rst = 1;
    tick();
    chk("mid_rst_valid", bus_if.out_valid, 0);
    chk("mid_rst_conflict", bus_if.conflict_cnt, 0);
    chk("mid_rst_suppress", bus_if.suppress_cnt, 0);
    chk("mid_rst_in_ready", bus_if.in_ready, 1);
    rst = 0;
    bus_if.out_ready = 1;

    // Randomized traffic
    bus_if.pos_limit = 15'($urandom_range(5, 40));
    for (int c = 0; c < 1500; c++) begin
      bus_if.cfg_we = ($urandom_range(0, 7) == 0);
      bus_if.cfg_sym = 2'($urandom_range(0, 3));
      bus_if.cfg_addr = 2'($urandom_range(0, 3));
      case (bus_if.cfg_addr)
        2'd0: bus_if.cfg_wdata = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                                               : $urandom_range(900, 1100);
        2'd3: bus_if.cfg_wdata = $urandom_range(0, 5);
        default: bus_if.cfg_wdata = $urandom_range(0, 60);
      endcase
      if (!bus_if.in_valid || acc_last) begin
        bus_if.in_valid = ($urandom_range(0, 9) < 6);
        bus_if.in_sym = 2'($urandom_range(0, 3));
        bus_if.bid_px0 = $urandom_range(800, 1300);
        bus_if.ask_px0 = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 64)
                                                       : $urandom_range(800, 1300);
      end
      bus_if.out_ready = ($urandom_range(0, 9) < 7);
      bus_if.fill_valid = ($urandom_range(0, 4) == 0);
      bus_if.fill_sym = 2'($urandom_range(0, 3));
      bus_if.fill_side = 1'($urandom_range(0, 1));
      bus_if.fill_qty = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15));
      tick();
    end
    bus_if.in_valid = 0; bus_if.cfg_we = 0; bus_if.fill_valid = 0; bus_if.out_ready = 1;
    drain();
    chk("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
